// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and default latencies; MDU_MADD_EN adds MADD/MADDU to the multi-cycle set
package mdu_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  function automatic logic is_multi(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU || op == MD_MADD || op == MD_MADDU;
`else
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
`endif
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: pipeline-to-MDU operation, stall and HI/LO bundle
interface mdu_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, md_op, A, B, md_use_d, input busy, stall, HI, LO);
  modport slave  (input start, md_op, A, B, md_use_d, output busy, stall, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {HI,LO} result from latched op/operands; MDU_MADD_EN adds the accumulate path
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] res
);
  logic [63:0] smul, umul;
  logic [31:0] dn, dd, q, r, sq, sr;
  logic        sgn;
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'b0, a} * {32'b0, b};
  assign sgn  = op == MD_DIV;
  // one unsigned divider on magnitudes serves both DIV and DIVU
  assign dn = sgn & a[31] ? -a : a;
  assign dd = sgn & b[31] ? -b : b;
  assign q  = dn / dd;
  assign r  = dn % dd;
  assign sq = sgn & (a[31] ^ b[31]) ? -q : q;
  assign sr = sgn & a[31] ? -r : r;
  always_comb begin
    res = acc;
    if (op == MD_MULT) res = smul;
    else if (op == MD_MULTU) res = umul;
    else if (is_div(op)) res = b == 32'd0 ? acc : {sr, sq};
`ifdef MDU_MADD_EN
    else if (op == MD_MADD) res = acc + smul;
    else if (op == MD_MADDU) res = acc + umul;
`endif
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer owning HI/LO with D-stage stall; MDU_MADD_EN enables MADD/MADDU
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  mdu_if.slave s
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  state_e      state;
  logic [CW-1:0] cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q, hi, lo;
  logic        busy;
  logic [63:0] res;
  mdu_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .acc ({hi, lo}),
    .res (res)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (s.start && is_multi(s.md_op)) begin
        op_q  <= s.md_op;
        a_q   <= s.A;
        b_q   <= s.B;
        cnt   <= is_div(s.md_op) ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
        state <= ST_RUN;
        busy  <= 1'b1;
      end else if (s.start && s.md_op == MD_MTHI) begin
        hi <= s.A;
      end else if (s.start && s.md_op == MD_MTLO) begin
        lo <= s.A;
      end
    end else if (cnt == '0) begin
      {hi, lo} <= res;
      state    <= ST_IDLE;
      busy     <= 1'b0;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
  assign s.busy  = busy;
  assign s.stall = s.md_use_d & (busy | (s.start & is_multi(s.md_op)));
  assign s.HI    = hi;
  assign s.LO    = lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed MDU tests checked against a cycle-level behavioural model of HI/LO, busy and stall
module tb_mdu_ctrl;
  localparam int ML = 5;
  localparam int DL = 10;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int fails = 0;
  int m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_a = '0, p_b = '0;
  logic [3:0]  p_op = '0;
  mdu_if bus ();
  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic multi_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
`else
    return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
  endfunction

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
    int q, r;
    logic [63:0] sp, up;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 0) return acc;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      4'd4: return b == 0 ? acc : {a % b, a / b};
      4'd7: return acc + sp;
      4'd8: return acc + up;
      default: return acc;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) {m_hi, m_lo} <= model_res(p_op, p_a, p_b, {m_hi, m_lo});
      if (bus.start) begin
        checks++;
        fails++;
        $display("FAIL start_while_busy op=%0d t=%0t", bus.md_op, $time);
      end
    end else if (bus.start) begin
      if (multi_op(bus.md_op)) begin
        p_op  <= bus.md_op;
        p_a   <= bus.A;
        p_b   <= bus.B;
        m_rem <= (bus.md_op inside {4'd3, 4'd4}) ? DL : ML;
      end else if (bus.md_op == 4'd5) m_hi <= bus.A;
      else if (bus.md_op == 4'd6) m_lo <= bus.A;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("model_busy", {31'b0, bus.busy}, {31'b0, m_rem > 0});
    chk("model_stall", {31'b0, bus.stall}, {31'b0, bus.md_use_d & ((m_rem > 0) | (bus.start & multi_op(bus.md_op)))});
    chk("model_hi", bus.HI, m_hi);
    chk("model_lo", bus.LO, m_lo);
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A = a;
    bus.B = b;
    bus.md_use_d = use_d;
  endtask

  task automatic wait_idle(output int n, output int ns);
    n = 0;
    ns = 0;
    while (bus.busy && n < 200) begin
      n++;
      ns += int'(bus.stall);
      @(negedge clk);
    end
    if (n >= 200) begin
      fails++;
      $display("FAIL busy_timeout busy=%b required=0", bus.busy);
    end
  endtask

  task automatic op_run(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    int n, ns;
    drive(op, a, b, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n, ns);
    chk({name, "_lat"}, n, lat);
    chk({name, "_hi"}, bus.HI, ehi);
    chk({name, "_lo"}, bus.LO, elo);
  endtask

  initial begin
    int n, ns;
    bus.start = 1'b0;
    bus.md_op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.md_use_d = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    op_run("mult", 4'd1, 32'hFFFFFFFF, 32'd2, ML, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_run("multu", 4'd2, 32'hFFFFFFFF, 32'd2, ML, 32'h00000001, 32'hFFFFFFFE);
    op_run("div", 4'd3, 32'hFFFFFFF9, 32'd2, DL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_run("divu_by0", 4'd4, 32'd7, 32'd0, DL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_run("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DL, 32'h0, 32'h80000000);
    op_run("divu", 4'd4, 32'hFFFFFFF9, 32'd2, DL, 32'h1, 32'h7FFFFFFC);
    op_run("div_pos_neg", 4'd3, 32'd7, 32'hFFFFFFFE, DL, 32'h1, 32'hFFFFFFFD);
    drive(4'd5, 32'h12345678, 32'd0, 1'b1);
    @(negedge clk);
    chk("mthi_hi", bus.HI, 32'h12345678);
    chk("mthi_lo", bus.LO, 32'hFFFFFFFD);
    drive(4'd6, 32'h9ABCDEF0, 32'd0, 1'b1);
    #1 chk("mtlo_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_lo", bus.LO, 32'h9ABCDEF0);
    chk("mtlo_busy", {31'b0, bus.busy}, 32'd0);
    drive(4'd1, 32'd3, 32'd4, 1'b1);
    #1 chk("stall_start", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n, ns);
    chk("stall_busy_cycles", ns, ML);
    chk("stall_fall", {31'b0, bus.stall}, 32'd0);
    chk("mult34_lo", bus.LO, 32'd12);
    drive(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_accept", {31'b0, bus.busy}, 32'd1);
    wait_idle(n, ns);
    chk("b2b_hi", bus.HI, 32'd0);
    chk("b2b_lo", bus.LO, 32'd1);
`ifdef MDU_MADD_EN
    op_run("madd", 4'd7, 32'd3, 32'd4, ML, 32'd0, 32'd13);
`else
    drive(4'd7, 32'd3, 32'd4, 1'b1);
    #1 chk("op7_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("op7_busy", {31'b0, bus.busy}, 32'd0);
    chk("op7_lo", bus.LO, 32'd1);
`endif
    drive(4'd9, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("op9_busy", {31'b0, bus.busy}, 32'd0);
    drive(4'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (DL + 2) @(negedge clk);
    chk("rst_after_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_after_hi", bus.HI, 32'd0);
    chk("rst_after_lo", bus.LO, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the pipelined MIPS core. It sits beside the ALU in the E stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the pipeline. It runs multi-cycle operations with a fixed latency and owns the architectural HI/LO registers. It raises a stall request so the D stage holds any HI/LO-dependent instruction until the unit is free.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); ≥1
- DIV_LAT, 10, busy cycles for DIV/DIVU; ≥1

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage operation valid, qualifies md_op
- md_op  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU (7/8 only with MDU_MADD_EN)
- A  in  32  rs operand
- B  in  32  rt operand
- md_use_d  in  1  D-stage instruction reads or writes HI/LO (incl. MFHI/MFLO)
- busy  out  1  multi-cycle op in flight
- stall  out  1  D-stage stall request
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- States: IDLE, RUN. Reset → IDLE, busy=0, HI=0, LO=0, counter=0, latched operands/op cleared.
- IDLE, start=1, md_op ∈ {MULT,MULTU,DIV,DIVU,MADD,MADDU}: latch A, B, op; counter ← latency−1; → RUN.
- IDLE, start=1, MTHI: HI ← A at the same edge. MTLO: LO ← A. The unit stays IDLE and busy stays 0.
- start with NONE or an unsupported op: no effect.
- RUN: counter decrements each cycle. When counter==0: write HI/LO, → IDLE.
- start while RUN: ignored. The pipeline guarantees this cannot happen via stall. The bench flags it as an error.
- MULT: {HI,LO} ← signed 64-bit A×B. MULTU: unsigned.
- DIV: LO ← quotient truncated toward zero; HI ← remainder with the dividend's sign. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero (B==0): HI/LO unchanged; full latency still consumed.
- Result is computed from the latched operands, not live A/B.
- stall = md_use_d & (busy | (start & md_op multi-cycle)). MTHI/MTLO never cause stall.

## Timing
- Multi-cycle op accepted at edge T: busy=1 from T+1 through T+LAT.
- HI/LO are updated at edge T+LAT and visible from T+LAT+1. busy=0 from T+LAT+1.
- Back-to-back: a new start is accepted at the same edge busy falls (T+LAT+1 cycle edge), giving zero dead cycles.
- MTHI/MTLO: value visible one cycle after the start edge.
- Reset asserted mid-RUN: the op is discarded immediately (async), busy=0, HI=LO=0. After release: IDLE.
- busy and stall are glitch-free from registers. stall adds only an AND with the start/md_use_d inputs.

## Configuration
- MDU_MADD_EN defined: ops 7/8 are supported. MADD: {HI,LO} ← {HI,LO} + signed A×B. MADDU: unsigned product. Both use MULT_LAT. The accumulator base is sampled at completion, so the HI/LO value at T+LAT is used.
- MDU_MADD_EN undefined: ops 7/8 are treated as NONE, with no accumulate adder in the netlist.

## Structure
- Package mdu_pkg: md_op encodings (MD_NONE..MD_MADDU), state encoding (ST_IDLE, ST_RUN), default latency constants.
- One sub-module, mdu_arith: combinational 64-bit result from latched op/A/B/{HI,LO}. It implements the signed/unsigned multiply, divide, divide-by-zero hold and MADD accumulate. The sequencer, counter, HI/LO registers and stall logic stay in mdu_ctrl.

## Test plan
- MULT A=0xFFFFFFFF, B=2 → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → HI/LO keep their prior values; busy lasts 10 cycles.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles → HI/LO updated one cycle each; busy=0 and stall=0 throughout.
- MULT started with md_use_d=1 held high → stall=1 on the start cycle and all 5 busy cycles, and 0 on the cycle busy falls. A second MULT issued on that cycle is accepted.
- reset_n pulsed low at cycle 3 of a DIV → busy=0, HI=LO=0 immediately; no late write-back after release.
- With MDU_MADD_EN: HI:LO=0x00000000_00000001, MADD A=3, B=4 → HI=0, LO=0x0000000D. Without the macro, op 7 → no change and busy=0.
